mult_div: RTL

- Multicycle signed multiply/divide unit feeding HI/LO, driven directly by the control unit's MULT/DIV states.
- Control unit pulses a start strobe, stalls until `done`, then selects HI/LO through the MEMtoReg mux (mfhi/mflo).
- Operands come from registers A and B. A single unit is shared by mult and div; it never writes the register file itself.

---
 rtl/mult_div.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/mult_div.sv
// mult_div: multicycle signed multiply/divide unit that feeds HI/LO.
//
// The control unit pulses mult_start or div_start for one cycle with the
// operands on A_in/B_in, stalls while busy is high, and picks up HI_out/LO_out
// once done pulses. The unit never writes the register file itself.
//
//   Multiply: radix-2 Booth, one step per cycle, {HI,LO} = full signed product.
//   Divide:   restoring division on operand magnitudes, one quotient bit per
//             cycle. LO = quotient (truncated toward zero), HI = remainder with
//             the sign of the dividend.
//   Latency:  strobe in cycle 0, busy in cycles 1..WIDTH+1, done and HI/LO
//             update in cycle WIDTH+1. A new strobe is accepted the cycle after.
//
// Optional feature (macro DIVZERO_EXC_EN):
//   defined   - divide by zero finishes in one cycle, done and div_zero pulse
//               together, and HI/LO keep their previous values.
//   undefined - div_zero is tied low; divide by zero runs the full sequence
//               and yields LO = all ones, HI = dividend.
//
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset
//   mult_start 1-cycle strobe, start signed A*B
//   div_start  1-cycle strobe, start signed A/B (mult_start wins if both)
//   A_in       multiplicand / dividend
//   B_in       multiplier / divisor
//   HI_out     product upper half / remainder
//   LO_out     product lower half / quotient
//   busy       high while an operation is in progress
//   done       1-cycle pulse, HI/LO updated this cycle
//   div_zero   1-cycle pulse, divide by zero detected (feature-gated)

module mult_div #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic [WIDTH-1:0] HI_out,
    output logic [WIDTH-1:0] LO_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    typedef enum logic [1:0] {IDLE, MULT, DIV, FIN} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    // Booth: acc_q is the sign-extended upper partial product, q_q the
    // multiplier shifting out. Divide: acc_q is the partial remainder, q_q
    // the dividend shifting out / quotient shifting in.
    logic [WIDTH:0]   acc_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] m_q;
    logic             qm1_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH:0]   m_ext;
    logic [WIDTH:0]   booth_sum;
    logic [WIDTH:0]   booth_acc_d;
    logic [WIDTH-1:0] booth_q_d;
    logic             booth_qm1_d;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   div_acc_d;
    logic [WIDTH-1:0] div_q_d;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             last_step;

    always_comb begin
        // One extra accumulator bit keeps acc +/- M from overflowing,
        // including the M = -2^(WIDTH-1) corner.
        m_ext = {m_q[WIDTH-1], m_q};
        case ({q_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + m_ext;
            2'b10:   booth_sum = acc_q - m_ext;
            default: booth_sum = acc_q;
        endcase
        {booth_acc_d, booth_q_d, booth_qm1_d} = {booth_sum[WIDTH], booth_sum, q_q};

        // Remainder stays below the divisor magnitude, so the shifted value
        // fits in WIDTH+1 bits; the extra trial bit is the borrow.
        rem_sh = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        trial  = {1'b0, rem_sh} - {2'b00, m_q};
        if (!trial[WIDTH+1]) begin
            div_acc_d = trial[WIDTH:0];
            div_q_d   = {q_q[WIDTH-2:0], 1'b1};
        end else begin
            div_acc_d = rem_sh;
            div_q_d   = {q_q[WIDTH-2:0], 1'b0};
        end
        quot_fix = neg_q_q ? -div_q_d : div_q_d;
        rem_fix  = neg_r_q ? -div_acc_d[WIDTH-1:0] : div_acc_d[WIDTH-1:0];

        a_mag     = A_in[WIDTH-1] ? -A_in : A_in;
        b_mag     = B_in[WIDTH-1] ? -B_in : B_in;
        last_step = (cnt_q == CNT_W'(WIDTH - 1));
    end

`ifdef DIVZERO_EXC_EN
    logic dz_q;
    assign div_zero = dz_q;
`else
    assign div_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            qm1_q   <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DIVZERO_EXC_EN
            dz_q    <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef DIVZERO_EXC_EN
            dz_q   <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (mult_start) begin
                        acc_q   <= '0;
                        q_q     <= B_in;
                        m_q     <= A_in;
                        qm1_q   <= 1'b0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= MULT;
                    end else if (div_start) begin
`ifdef DIVZERO_EXC_EN
                        if (B_in == '0) begin
                            done_q  <= 1'b1;
                            dz_q    <= 1'b1;
                            busy_q  <= 1'b1;
                            state_q <= FIN;
                        end else
`endif
                        begin
                            acc_q   <= '0;
                            q_q     <= a_mag;
                            m_q     <= b_mag;
                            // A zero divisor leaves the all-ones quotient
                            // unsigned so LO reads back as all ones.
                            neg_q_q <= (A_in[WIDTH-1] ^ B_in[WIDTH-1]) && (B_in != '0);
                            neg_r_q <= A_in[WIDTH-1];
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= DIV;
                        end
                    end
                end
                MULT: begin
                    acc_q <= booth_acc_d;
                    q_q   <= booth_q_d;
                    qm1_q <= booth_qm1_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_step) begin
                        hi_q    <= booth_acc_d[WIDTH-1:0];
                        lo_q    <= booth_q_d;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end
                end
                DIV: begin
                    acc_q <= div_acc_d;
                    q_q   <= div_q_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_step) begin
                        hi_q    <= rem_fix;
                        lo_q    <= quot_fix;
                        done_q  <= 1'b1;
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign HI_out = hi_q;
    assign LO_out = lo_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
